// File: rtl/gpu_op_pkg.sv
// Shared GPU draw-operation definitions.
// Holds the op payload struct, field widths and the bird sprite constants
// used by any block that produces or consumes draw ops.
package gpu_op_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned COLOR_W = 4;
  localparam int unsigned SCALE_W = 2;

  // One rectangle draw: fill with color, or blit from sprite memory when mem_en=1.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_en;
    logic [COLOR_W-1:0] color;
    logic [SCALE_W-1:0] scale;
  } gpu_op_t;

  localparam int unsigned        BIRD_W        = 16;
  localparam int unsigned        BIRD_H        = 12;
  localparam logic [ADDR_W-1:0]  BIRD_MEM_ADDR = 16'h0400;
  localparam logic [SCALE_W-1:0] BIRD_SCALE    = 2'd2;

  localparam logic [COLOR_W-1:0] COLOR_BG   = 4'd0;
  localparam logic [COLOR_W-1:0] COLOR_PIPE = 4'd1;

endpackage

// File: rtl/gpu_op_seq.sv
// Per-frame draw-list sequencer for the flappy-bird scene.
// On frame_start it snapshots the scene inputs and emits up to four draw ops
// (clear, top pipe, bottom pipe, bird) over a valid/ready handshake, skipping
// ops that fall fully off screen and clipping ones that hang off the edge.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ce                clock enable; nothing advances while low
//   frame_start       request a new frame's draw list (honoured only when idle)
//   bird_y, pipe_x,
//   pipe_gap_y        scene geometry, sampled on frame_start
//   op, op_valid,
//   op_ready          draw-op output handshake
//   busy              a frame's list is in progress
//   frame_done        one-cycle pulse when the list completes
module gpu_op_seq
  import gpu_op_pkg::*;
#(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  parameter int unsigned PIPE_WIDTH        = 52,
  parameter int unsigned GAP_HEIGHT        = 120,
  parameter int unsigned BIRD_X            = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] bird_y,
  input  logic [COORD_W-1:0] pipe_x,
  input  logic [COORD_W-1:0] pipe_gap_y,
  output gpu_op_t            op,
  output logic               op_valid,
  input  logic               op_ready,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned EXT_W = COORD_W + 1;

  localparam logic [EXT_W-1:0] HOR_E    = EXT_W'(HOR_ACTIVE_PIXELS);
  localparam logic [EXT_W-1:0] VER_E    = EXT_W'(VER_ACTIVE_PIXELS);
  localparam logic [EXT_W-1:0] PIPE_W_E = EXT_W'(PIPE_WIDTH);
  localparam logic [EXT_W-1:0] GAP_H_E  = EXT_W'(GAP_HEIGHT);
  localparam logic [EXT_W-1:0] BIRD_H_E = EXT_W'(BIRD_H);

  typedef enum logic [1:0] {IDLE, BUILD, SEND} state_t;

  state_t             state;
  logic [1:0]         idx;
  logic [COORD_W-1:0] bird_y_q;
  logic [COORD_W-1:0] pipe_x_q;
  logic [COORD_W-1:0] gap_y_q;

  // One bit of headroom so edge sums and differences cannot wrap.
  logic [EXT_W-1:0] pipe_x_e, gap_y_e, bird_y_e, bot_y_e;
  logic [EXT_W-1:0] hor_rem, bot_h, bird_rem, pipe_w, bird_h;
  logic             pipe_off, bot_off, bird_off;

  gpu_op_t build_op;
  logic    build_skip;

  always_comb begin
    pipe_x_e = {1'b0, pipe_x_q};
    gap_y_e  = {1'b0, gap_y_q};
    bird_y_e = {1'b0, bird_y_q};
    bot_y_e  = gap_y_e + GAP_H_E;

    pipe_off = (pipe_x_e >= HOR_E);
    bot_off  = (bot_y_e >= VER_E);
    bird_off = (bird_y_e >= VER_E);

    // Differences are only used when the matching *_off flag is clear.
    hor_rem  = HOR_E - pipe_x_e;
    bot_h    = VER_E - bot_y_e;
    bird_rem = VER_E - bird_y_e;
    pipe_w   = (hor_rem < PIPE_W_E) ? hor_rem : PIPE_W_E;
    bird_h   = (bird_rem < BIRD_H_E) ? bird_rem : BIRD_H_E;
  end

  // Combinational op for the current index, registered in BUILD.
  always_comb begin
    build_op   = '0;
    build_skip = 1'b0;
    unique case (idx)
      2'd0: begin
        build_op.width  = COORD_W'(HOR_ACTIVE_PIXELS);
        build_op.height = COORD_W'(VER_ACTIVE_PIXELS);
        build_op.color  = COLOR_BG;
      end
      2'd1: begin
        build_op.x      = pipe_x_q;
        build_op.width  = COORD_W'(pipe_w);
        build_op.height = gap_y_q;
        build_op.color  = COLOR_PIPE;
        build_skip      = pipe_off || (gap_y_q == '0);
      end
      2'd2: begin
        build_op.x      = pipe_x_q;
        build_op.y      = COORD_W'(bot_y_e);
        build_op.width  = COORD_W'(pipe_w);
        build_op.height = COORD_W'(bot_h);
        build_op.color  = COLOR_PIPE;
        build_skip      = pipe_off || bot_off;
      end
      default: begin
        build_op.x        = COORD_W'(BIRD_X);
        build_op.y        = bird_y_q;
        build_op.width    = COORD_W'(BIRD_W);
        build_op.height   = COORD_W'(bird_h);
        build_op.mem_en   = 1'b1;
        build_op.mem_addr = BIRD_MEM_ADDR;
        build_op.scale    = BIRD_SCALE;
        build_skip        = bird_off;
      end
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      op         <= '0;
      op_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bird_y_q   <= '0;
      pipe_x_q   <= '0;
      gap_y_q    <= '0;
    end else if (ce) begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            bird_y_q <= bird_y;
            pipe_x_q <= pipe_x;
            gap_y_q  <= pipe_gap_y;
            idx      <= 2'd0;
            busy     <= 1'b1;
            state    <= BUILD;
          end
        end
        BUILD: begin
          if (!build_skip) begin
            op       <= build_op;
            op_valid <= 1'b1;
            state    <= SEND;
          end else if (idx == 2'd3) begin
            idx        <= 2'd0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        SEND: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            if (idx == 2'd3) begin
              idx        <= 2'd0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              idx   <= idx + 2'd1;
              state <= BUILD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_op_seq.sv
// Directed self-checking bench for gpu_op_seq (640x480 screen).
module tb_gpu_op_seq;
  import gpu_op_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               ce;
  logic               frame_start;
  logic [COORD_W-1:0] bird_y, pipe_x, pipe_gap_y;
  gpu_op_t            op;
  logic               op_valid, op_ready, busy, frame_done;

  gpu_op_seq #(
    .HOR_ACTIVE_PIXELS(640),
    .VER_ACTIVE_PIXELS(480),
    .PIPE_WIDTH(52),
    .GAP_HEIGHT(120),
    .BIRD_X(100)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .frame_start(frame_start),
    .bird_y(bird_y), .pipe_x(pipe_x), .pipe_gap_y(pipe_gap_y),
    .op(op), .op_valid(op_valid), .op_ready(op_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_errors = 0;
  int      fd_count = 0;
  logic    fd_prev  = 1'b0;
  logic    ce_mode  = 1'b0;
  gpu_op_t got_q[$];
  gpu_op_t exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic gpu_op_t mk_op(input int x, input int y, input int w, input int h,
                                    input bit men, input bit [3:0] color, input bit bird);
    gpu_op_t o;
    o          = '0;
    o.x        = COORD_W'(x);
    o.y        = COORD_W'(y);
    o.width    = COORD_W'(w);
    o.height   = COORD_W'(h);
    o.mem_en   = men;
    o.color    = color;
    o.mem_addr = bird ? 16'h0400 : 16'h0000;
    o.scale    = bird ? 2'd2 : 2'd0;
    return o;
  endfunction

  function automatic gpu_op_t clr_op();
    return mk_op(0, 0, 640, 480, 1'b0, 4'd0, 1'b0);
  endfunction

  function automatic gpu_op_t bird_op(input int y, input int h);
    return mk_op(100, y, 16, h, 1'b1, 4'd0, 1'b1);
  endfunction

  // Transfer/frame_done monitor; inputs change just after posedge, so
  // negedge values are the ones the next edge will use.
  always @(negedge clk) begin
    if (!rst && ce && op_valid && op_ready) got_q.push_back(op);
    if (frame_done && !fd_prev) fd_count++;
    fd_prev = frame_done;
  end

  // Clock enable: steady high, or toggling every cycle in ce_mode.
  always @(posedge clk) begin
    #1;
    ce = ce_mode ? ~ce : 1'b1;
  end

  task automatic set_scene(input int px, input int gy, input int by);
    pipe_x     = COORD_W'(px);
    pipe_gap_y = COORD_W'(gy);
    bird_y     = COORD_W'(by);
  endtask

  // Hold frame_start until an enabled edge has sampled it.
  task automatic start_frame();
    frame_start = 1'b1;
    do @(negedge clk); while (!ce);
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int start_cnt;
    int n;
    start_cnt = fd_count;
    n = 0;
    while (fd_count == start_cnt && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_done"}, 128'(fd_count - start_cnt), 128'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!op_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 128'(op_valid), 128'(1));
  endtask

  task automatic cmp_list(input string tag);
    chk({tag, "_nops"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_op%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
  endtask

  task automatic run_frame(input string tag, input int px, input int gy, input int by);
    got_q.delete();
    set_scene(px, gy, by);
    start_frame();
    wait_done(tag);
    cmp_list(tag);
  endtask

  function automatic void exp_a();
    exp_q.delete();
    exp_q.push_back(clr_op());
    exp_q.push_back(mk_op(300, 0, 52, 100, 1'b0, 4'd1, 1'b0));
    exp_q.push_back(mk_op(300, 220, 52, 260, 1'b0, 4'd1, 1'b0));
    exp_q.push_back(bird_op(200, 12));
  endfunction

  function automatic void exp_d();
    exp_q.delete();
    exp_q.push_back(clr_op());
    exp_q.push_back(mk_op(300, 120, 52, 360, 1'b0, 4'd1, 1'b0));
    exp_q.push_back(bird_op(475, 5));
  endfunction

  initial begin
    gpu_op_t held;
    int      fd_snap;
    rst = 1'b1; ce = 1'b1; frame_start = 1'b0; op_ready = 1'b1;
    set_scene(0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(op_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_fdone", 128'(frame_done), 128'(0));
    chk("rst_op", 128'(op), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Nominal frame plus first-op latency (valid 2 cycles after frame_start).
    got_q.delete();
    set_scene(300, 100, 200);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(negedge clk);
    chk("lat_busy", 128'(busy), 128'(1));
    chk("lat_v1", 128'(op_valid), 128'(0));
    @(negedge clk);
    chk("lat_v2", 128'(op_valid), 128'(1));
    wait_done("nom");
    exp_a();
    cmp_list("nom");

    // Right-edge clipping and fully off-screen pipe.
    exp_q.delete();
    exp_q.push_back(clr_op());
    exp_q.push_back(mk_op(620, 0, 20, 100, 1'b0, 4'd1, 1'b0));
    exp_q.push_back(mk_op(620, 220, 20, 260, 1'b0, 4'd1, 1'b0));
    exp_q.push_back(bird_op(200, 12));
    run_frame("clip", 620, 100, 200);

    exp_q.delete();
    exp_q.push_back(clr_op());
    exp_q.push_back(bird_op(200, 12));
    run_frame("off", 700, 100, 200);

    // Zero gap skips top pipe; bird clipped at bottom.
    exp_d();
    run_frame("gap0", 300, 0, 475);

    // Bottom pipe pushed below the screen.
    exp_q.delete();
    exp_q.push_back(clr_op());
    exp_q.push_back(mk_op(300, 0, 52, 400, 1'b0, 4'd1, 1'b0));
    exp_q.push_back(bird_op(200, 12));
    run_frame("gap400", 300, 400, 200);

    // Bird off screen.
    exp_q.delete();
    exp_q.push_back(clr_op());
    exp_q.push_back(mk_op(300, 0, 52, 100, 1'b0, 4'd1, 1'b0));
    exp_q.push_back(mk_op(300, 220, 52, 260, 1'b0, 4'd1, 1'b0));
    run_frame("birdoff", 300, 100, 480);

    // Backpressure: op must hold while not accepted.
    got_q.delete();
    op_ready = 1'b0;
    set_scene(300, 100, 200);
    start_frame();
    wait_valid("stall");
    held = op;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stall_op%0d", i), 128'(op), 128'(held));
      chk($sformatf("stall_v%0d", i), 128'(op_valid), 128'(1));
    end
    @(posedge clk);
    #1 op_ready = 1'b1;
    wait_done("stall");
    exp_a();
    cmp_list("stall");

    // Second frame_start and scene changes while busy have no effect.
    got_q.delete();
    op_ready = 1'b0;
    set_scene(300, 100, 200);
    start_frame();
    wait_valid("busy");
    set_scene(700, 0, 475);
    @(posedge clk);
    #1;
    start_frame();
    op_ready = 1'b1;
    wait_done("busy");
    cmp_list("busy");
    fd_snap = fd_count;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("busy_nofd", 128'(fd_count), 128'(fd_snap));
    chk("busy_idle", 128'(busy), 128'(0));
    chk("busy_nops", 128'(got_q.size()), 128'(4));
    @(posedge clk);
    #1;

    // Reset while the top-pipe op is waiting, then clean restart.
    got_q.delete();
    op_ready = 1'b0;
    set_scene(300, 100, 200);
    start_frame();
    wait_valid("rs0");
    @(posedge clk);
    #1 op_ready = 1'b1;
    @(posedge clk);
    #1 op_ready = 1'b0;
    wait_valid("rs1");
    chk("rs1_x", 128'(op.x), 128'(300));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rs_valid", 128'(op_valid), 128'(0));
    chk("rs_busy", 128'(busy), 128'(0));
    chk("rs_op", 128'(op), 128'(0));
    chk("rs_nops", 128'(got_q.size()), 128'(1));
    @(posedge clk);
    #1 op_ready = 1'b1;
    exp_a();
    run_frame("rsre", 300, 100, 200);

    // Half-rate clock enable: same op lists.
    ce_mode = 1'b1;
    exp_a();
    run_frame("ce_a", 300, 100, 200);
    exp_d();
    run_frame("ce_d", 300, 0, 475);
    ce_mode = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpu_op_seq.md
GPU_OP_SEQ -- requirements
Module: gpu_op_seq

Interface
REQ-001 Parameters SHALL be: HOR_ACTIVE_PIXELS, none, screen width; VER_ACTIVE_PIXELS, none, screen height; PIPE_WIDTH, 52, pipe width in pixels; GAP_HEIGHT, 120, vertical gap between the pipes; BIRD_X, 100, fixed bird column.
REQ-002 Ports SHALL be:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ce  in  1  clock enable; all state advances only when high
frame_start  in  1  one-cycle pulse requesting a new frame's draw list
bird_y  in  11  bird top row
pipe_x  in  11  pipe left column
pipe_gap_y  in  11  first row of the gap
op  out  gpu_op_t  draw operation (x, y, width, height, mem_addr, mem_en, color, scale)
op_valid  out  1  op is valid
op_ready  in  1  sink accepts op
busy  out  1  sequence in progress
frame_done  out  1  one-cycle pulse after the last op transfers

Function
REQ-003 A transfer SHALL occur on a clk edge with ce=1, op_valid=1 and op_ready=1; op SHALL stay constant while op_valid=1 and the transfer has not occurred.
REQ-004 The FSM SHALL have states IDLE, BUILD and SEND, with a 2-bit op index idx.
REQ-005 IDLE with frame_start=1 SHALL snapshot bird_y, pipe_x and pipe_gap_y, set idx=0 and busy=1, and go to BUILD; frame_start outside IDLE SHALL be ignored.
REQ-006 The draw list SHALL be:
- idx0, clear: x=0, y=0, w=HOR, h=VER, mem_en=0, color=0.
- idx1, top pipe: x=pipe_x, y=0, w=min(PIPE_WIDTH, HOR-pipe_x), h=pipe_gap_y, color=1.
- idx2, bottom pipe: x=pipe_x, y=pipe_gap_y+GAP_HEIGHT, same w, h=VER-y, color=1.
- idx3, bird: x=BIRD_X, y=bird_y, w=BIRD_W, h=min(BIRD_H, VER-bird_y), mem_en=1, mem_addr=BIRD_MEM_ADDR, scale=BIRD_SCALE.
REQ-007 Ops SHALL be skipped as follows:
- idx1/idx2 when pipe_x>=HOR.
- idx1 when pipe_gap_y=0.
- idx2 when pipe_gap_y+GAP_HEIGHT>=VER.
- idx3 when bird_y>=VER.
REQ-008 Clipping arithmetic SHALL use 12-bit intermediates so that sums never wrap.
REQ-009 BUILD for a non-skipped op SHALL register op, set op_valid=1 and go to SEND; for a skipped op it SHALL advance idx, or finish if idx=3, without asserting op_valid.
REQ-010 SEND on transfer SHALL clear op_valid in the same edge; if idx=3 it SHALL pulse frame_done, clear busy and go to IDLE; otherwise it SHALL increment idx and go to BUILD.
REQ-011 The minimum spacing SHALL be one idle cycle between consecutive ops, and the first op_valid SHALL rise 2 ce-cycles after frame_start.
REQ-012 Changes on bird_y, pipe_x and pipe_gap_y during busy=1 SHALL NOT affect the current frame.
REQ-013 With ce=0, all outputs and state SHALL hold; frame_start and op_ready SHALL be ignored.

Reset
REQ-014 rst=1 SHALL force IDLE, idx=0, op='0, op_valid=0, busy=0 and frame_done=0, overriding ce, including mid-SEND; no transfer SHALL be counted on that edge.

Structure
REQ-015 gpu_op_t, BIRD_W=16, BIRD_H=12, BIRD_MEM_ADDR and BIRD_SCALE SHALL live in the shared gpu_op package/include, not in this module.
REQ-016 The block SHALL be a single module with no sub-module; the per-idx op build SHALL be combinational logic feeding the op register.

Verification (HOR=640, VER=480)
REQ-017 pipe_x=300, gap_y=100, bird_y=200, op_ready=1: ops SHALL be clear; (300,0,52,100); (300,220,52,260); bird (100,200,16,12); then one frame_done.
REQ-018 pipe_x=620: both pipe ops SHALL have w=20; pipe_x=700: only clear and bird SHALL be issued.
REQ-019 gap_y=0, bird_y=475: top pipe SHALL be skipped and bird h=5; gap_y=400: bottom pipe SHALL be skipped.
REQ-020 op_ready low for 10 cycles during SEND: op SHALL stay stable, op_valid SHALL stay high, and exactly one transfer SHALL be counted.
REQ-021 A second frame_start while busy, or inputs changed mid-frame, SHALL produce no effect; rst asserted in SEND of idx1 SHALL give op_valid=0 the next cycle and a clean restart on the next frame_start.
REQ-022 ce toggled at 50% SHALL produce an op sequence identical to ce=1, apart from timing.
